// File: rtl/poly_voice_mixer_if.sv
// Voice-mixer bus: per-voice inputs, envelope controls and the mixed output.
// Master drives stimulus and consumes the mix; slave is the mixer itself.
interface poly_voice_mixer_if #(
  parameter int NUM_VOICES = 12,
  parameter int SAMPLE_W   = 8,
  parameter int ENV_W      = 8
);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  logic                           sample_tick;
  logic [NUM_VOICES-1:0]          key_en;
  logic [NUM_VOICES*SAMPLE_W-1:0] samples;
  logic [ENV_W-1:0]               attack_step;
  logic [ENV_W-1:0]               release_step;
  logic                           clr_overrun;
  logic [SAMPLE_W-1:0]            out_sample;
  logic                           out_valid;
  logic [CNT_W-1:0]               active_count;
  logic                           busy;
  logic                           overrun;

  modport master (
    output sample_tick, key_en, samples, attack_step, release_step, clr_overrun,
    input  out_sample, out_valid, active_count, busy, overrun
  );

  modport slave (
    input  sample_tick, key_en, samples, attack_step, release_step, clr_overrun,
    output out_sample, out_valid, active_count, busy, overrun
  );
endinterface

// File: rtl/poly_voice_mixer.sv
// Time-multiplexed polyphonic mixer: per-voice linear envelopes, scaled accumulate,
// then a restoring divide by the audible-voice count to normalise the mix.
module poly_voice_mixer #(
  parameter int NUM_VOICES = 12,
  parameter int SAMPLE_W   = 8,
  parameter int ENV_W      = 8
) (
  input logic                clk,
  input logic                reset,
  poly_voice_mixer_if.slave  bus
);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int DIV_W = $clog2(ACC_W + 1);
  localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};
  localparam logic [ACC_W-1:0] SAT_LIM = {{(ACC_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_OUTPUT} state_e;

  state_e                state_q;
  logic [NUM_VOICES-1:0] key_q;
  logic [SAMPLE_W-1:0]   samp_q [NUM_VOICES];
  logic [ENV_W-1:0]      env_q  [NUM_VOICES];
  logic [ACC_W-1:0]      acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      rem_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DIV_W-1:0]      div_cnt_q;
  logic [SAMPLE_W-1:0]   out_sample_q;
  logic                  out_valid_q;
  logic [CNT_W-1:0]      active_count_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic [ENV_W-1:0]          env_cur_s;
  logic [ENV_W:0]            env_sum_s;
  logic [ENV_W-1:0]          env_new_s;
  logic [SAMPLE_W+ENV_W-1:0] prod_s;
  logic [SAMPLE_W-1:0]       scaled_s;
  logic [CNT_W:0]            trial_s;
  logic                      qbit_s;
  logic [CNT_W-1:0]          rem_d;
  logic [ACC_W-1:0]          acc_div_d;
  logic [SAMPLE_W-1:0]       quot_sat_s;

  // Envelope step, voice scaling and one restoring-divide iteration.
  always_comb begin
    env_cur_s = env_q[idx_q];
    env_sum_s = {1'b0, env_cur_s} + {1'b0, bus.attack_step};
    if (key_q[idx_q]) begin
      if (env_sum_s > {1'b0, ENV_MAX}) begin
        env_new_s = ENV_MAX;
      end else begin
        env_new_s = env_sum_s[ENV_W-1:0];
      end
    end else begin
      if (env_cur_s > bus.release_step) begin
        env_new_s = env_cur_s - bus.release_step;
      end else begin
        env_new_s = {ENV_W{1'b0}};
      end
    end
    prod_s   = {{ENV_W{1'b0}}, samp_q[idx_q]} * {{SAMPLE_W{1'b0}}, env_new_s};
    scaled_s = SAMPLE_W'(prod_s >> ENV_W);

    // Remainder always stays below the divisor, so modular subtraction is exact.
    trial_s = {rem_q, acc_q[ACC_W-1]};
    if (trial_s >= {1'b0, cnt_q}) begin
      qbit_s = 1'b1;
      rem_d  = trial_s[CNT_W-1:0] - cnt_q;
    end else begin
      qbit_s = 1'b0;
      rem_d  = trial_s[CNT_W-1:0];
    end
    acc_div_d = {acc_q[ACC_W-2:0], qbit_s};
    if (acc_div_d > SAT_LIM) begin
      quot_sat_s = {SAMPLE_W{1'b1}};
    end else begin
      quot_sat_s = acc_div_d[SAMPLE_W-1:0];
    end
  end

  // Mixer FSM with registered outputs and sticky overrun tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      key_q          <= {NUM_VOICES{1'b0}};
      acc_q          <= {ACC_W{1'b0}};
      cnt_q          <= {CNT_W{1'b0}};
      rem_q          <= {CNT_W{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      div_cnt_q      <= {DIV_W{1'b0}};
      out_sample_q   <= {SAMPLE_W{1'b0}};
      out_valid_q    <= 1'b0;
      active_count_q <= {CNT_W{1'b0}};
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i] <= {SAMPLE_W{1'b0}};
        env_q[i]  <= {ENV_W{1'b0}};
      end
    end else begin
      if (bus.sample_tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (bus.sample_tick) begin
            key_q <= bus.key_en;
            for (int i = 0; i < NUM_VOICES; i++) begin
              samp_q[i] <= bus.samples[i*SAMPLE_W +: SAMPLE_W];
            end
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_ACCUM: begin
          env_q[idx_q] <= env_new_s;
          acc_q        <= acc_q + {{(ACC_W-SAMPLE_W){1'b0}}, scaled_s};
          if (env_new_s != {ENV_W{1'b0}}) begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
          end
          if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
            rem_q     <= {CNT_W{1'b0}};
            div_cnt_q <= {DIV_W{1'b0}};
            state_q   <= S_DIVIDE;
          end else begin
            idx_q <= idx_q + IDX_W'(1'b1);
          end
        end
        S_DIVIDE: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            out_sample_q   <= {SAMPLE_W{1'b0}};
            active_count_q <= cnt_q;
            out_valid_q    <= 1'b1;
            state_q        <= S_OUTPUT;
          end else begin
            acc_q     <= acc_div_d;
            rem_q     <= rem_d;
            div_cnt_q <= div_cnt_q + DIV_W'(1'b1);
            if (div_cnt_q == DIV_W'(ACC_W - 1)) begin
              out_sample_q   <= quot_sat_s;
              active_count_q <= cnt_q;
              out_valid_q    <= 1'b1;
              state_q        <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_sample   = out_sample_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.active_count = active_count_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Randomised and directed bench for poly_voice_mixer (4 voices) against an
// arithmetic model of envelopes, averaging, latency and overrun.
module tb_poly_voice_mixer;
  localparam int NV = 4;
  localparam int SW = 8;
  localparam int EW = 8;
  localparam int AW = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   env_m [NV];
  int   att_m;
  int   rel_m;
  bit   ov_m;

  poly_voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ENV_W(EW)) bus ();

  poly_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ENV_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_steps(input int a, input int r);
    att_m            = a;
    rel_m            = r;
    bus.attack_step  = a[EW-1:0];
    bus.release_step = r[EW-1:0];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sample"}, 32'(bus.out_sample), 32'd0);
    chk({tag, "_valid"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_count"},  32'(bus.active_count), 32'd0);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_ovr"},    32'(bus.overrun), 32'd0);
  endtask

  task automatic plain_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NV; i++) env_m[i] = 0;
    ov_m = 1'b0;
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One accepted tick; optional busy tick at ovr_cyc and clear pulse at clr_cyc (0 = none).
  task automatic do_op(input logic [NV-1:0] keys, input logic [NV*SW-1:0] samp,
                       input int ovr_in, input int clr_in);
    int acc, cnt, q, lat, first, npulse, s, ovr_cyc, clr_cyc;
    acc = 0;
    cnt = 0;
    for (int v = 0; v < NV; v++) begin
      s = int'(samp[v*SW +: SW]);
      if (keys[v]) env_m[v] = (env_m[v] + att_m > 255) ? 255 : env_m[v] + att_m;
      else         env_m[v] = (env_m[v] > rel_m) ? env_m[v] - rel_m : 0;
      acc += (s * env_m[v]) / 256;
      if (env_m[v] != 0) cnt++;
    end
    q = (cnt == 0) ? 0 : acc / cnt;
    if (q > 255) q = 255;
    lat = (cnt == 0) ? NV + 2 : NV + AW + 1;
    ovr_cyc = (ovr_in > lat) ? lat : ovr_in;
    clr_cyc = (clr_in > lat + 3) ? lat + 3 : clr_in;
    for (int c = 1; c <= lat + 3; c++) begin
      if (c == ovr_cyc) ov_m = 1'b1;
      else if (c == clr_cyc) ov_m = 1'b0;
    end

    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    bus.key_en      = keys;
    bus.samples     = samp;
    @(posedge clk); #1;
    first  = -1;
    npulse = 0;
    for (int c = 1; c <= lat + 3; c++) begin
      bus.sample_tick = (c == ovr_cyc);
      bus.clr_overrun = (c == clr_cyc);
      if (c == 1) begin
        bus.key_en  = NV'($urandom);
        bus.samples = NV*SW'({$urandom, $urandom});
      end
      @(negedge clk);
      if (c == 1) chk("busy_start", 32'(bus.busy), 32'd1);
      if (bus.out_valid) begin
        npulse++;
        if (first < 0) first = c;
      end
      @(posedge clk); #1;
    end
    bus.sample_tick = 1'b0;
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    chk("latency", 32'(first), 32'(lat));
    chk("pulses", 32'(npulse), 32'd1);
    chk("out_sample", 32'(bus.out_sample), 32'(q));
    chk("active_count", 32'(bus.active_count), 32'(cnt));
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("overrun", 32'(bus.overrun), 32'(ov_m));
  endtask

  initial begin
    int npulse;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.sample_tick = 1'b0;
    bus.key_en      = '0;
    bus.samples     = '0;
    bus.clr_overrun = 1'b0;
    set_steps(0, 0);
    for (int i = 0; i < NV; i++) env_m[i] = 0;
    ov_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    @(posedge clk); #1;
    reset = 1'b1;

    set_steps(255, 0);
    do_op(4'b0001, 32'd200, 0, 0);

    // Reset at cycle 2 of an accumulation: abort, no pulse, envelopes cleared.
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    bus.key_en      = 4'b0001;
    bus.samples     = 32'd200;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NV; i++) env_m[i] = 0;
    ov_m = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    reset  = 1'b1;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) npulse++;
    end
    chk("mid_rst_nopulse", 32'(npulse), 32'd0);

    set_steps(64, 0);
    do_op(4'b0001, 32'd200, 0, 0);
    set_steps(255, 0);
    do_op(4'b0011, {16'd0, 8'd200, 8'd100}, 0, 0);

    plain_reset();
    set_steps(64, 0);
    for (int t = 0; t < 4; t++) do_op(4'b0001, 32'd255, 0, 0);
    set_steps(0, 128);
    do_op(4'b0000, 32'd255, 0, 0);
    do_op(4'b0000, 32'd255, 0, 0);

    set_steps(255, 0);
    do_op(4'b0001, 32'd180, 5, 0);
    @(posedge clk); #1;
    bus.clr_overrun = 1'b1;
    ov_m = 1'b0;
    @(posedge clk); #1;
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    chk("ovr_clear", 32'(bus.overrun), 32'd0);
    do_op(4'b0001, 32'd90, 3, 3);

    for (int t = 0; t < 40; t++) begin
      set_steps(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      do_op(NV'($urandom), NV*SW'({$urandom, $urandom}),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
